sd_sector_buffer: RTL

- Consumer stage directly downstream of the SD sector reader, and the CPU-side front end for disk reads.
- Accepts a sector request from the MIPS side and drives the reader's rd_en/rd_addr.
- Collects the 256 16-bit words the reader streams out and packs them into a 128 x 32-bit buffer.
- Exposes that buffer through a registered read port, with done/valid/error status.

---
 rtl/sd_pkg.sv | 15 +
 rtl/sd_buf_ram.sv | 34 +++
 rtl/sd_sector_buffer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD sector buffer: FSM encoding and geometry constants.
package sd_pkg;

    localparam int SD_SECTOR_WORDS16 = 256;
    localparam int SD_BUF_AW         = 7;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_FILL      = 3'd3,
        ST_FINISH    = 3'd4
    } sd_state_e;

endpackage

// File: rtl/sd_buf_ram.sv
// Simple dual-port sector RAM: one write port, one registered read port (block-RAM style).
module sd_buf_ram #(
    parameter int AW = 7,
    parameter int DW = 32
) (
    input  logic          sys_clk_shift,
    input  logic          sys_rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // NOTE: the array has no reset branch on purpose; a reset loop over every word
    // would stop the array mapping onto block RAM.
    always_ff @(posedge sys_clk_shift) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-address read and write in one cycle returns the old word.
    always_ff @(posedge sys_clk_shift or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sd_sector_buffer.sv
// CPU-side sector buffer: requests a sector from the SD reader, packs 16-bit words into 32-bit RAM.
// Optional macro SD_SECTOR_CACHE_EN: a repeat request for the valid sector completes without a reload.
module sd_sector_buffer
    import sd_pkg::*;
#(
    parameter int WORDS16       = SD_SECTOR_WORDS16,
    parameter int START_TIMEOUT = 1024,
    parameter int AW            = SD_BUF_AW
) (
    input  logic          sys_clk_shift,
    input  logic          sys_rst_n,
    input  logic          req,
    input  logic [31:0]   req_sector,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          rd_en,
    output logic [31:0]   rd_addr,
    input  logic          rd_busy,
    input  logic          rd_data_en,
    input  logic [15:0]   rd_data,
    input  logic [AW-1:0] buf_raddr,
    output logic [31:0]   buf_rdata,
    output logic          buf_valid,
    output logic [31:0]   cur_sector
);

    localparam int WCW = $clog2(WORDS16 + 1);
    localparam int TW  = $clog2(START_TIMEOUT);
    localparam logic [WCW-1:0] WCNT_FULL = WCW'(WORDS16);
    localparam logic [TW-1:0]  TCNT_LAST = TW'(START_TIMEOUT - 1);

    sd_state_e      state_q;
    sd_state_e      state_d;
    logic [WCW-1:0] wcnt;
    logic [TW-1:0]  tcnt;
    logic [15:0]    hi_half;
    logic           overrun;
    logic           rd_busy_q;

    logic accept;
    logic cache_hit;
    logic start_load;
    logic issuing;
    logic timeout;
    logic busy_fall;
    logic fill_ok;
    logic strobe;
    logic ram_we;

`ifdef SD_SECTOR_CACHE_EN
    assign cache_hit = buf_valid && (req_sector == cur_sector);
`else
    assign cache_hit = 1'b0;
`endif

    assign accept     = (state_q == ST_IDLE) && req;
    assign start_load = accept && !cache_hit;
    assign issuing    = (state_q == ST_ISSUE) || (state_q == ST_WAIT_BUSY);
    assign timeout    = !rd_busy && (tcnt == TCNT_LAST);
    assign busy_fall  = rd_busy_q && !rd_busy;
    assign fill_ok    = (wcnt == WCNT_FULL) && !overrun;
    assign strobe     = (state_q == ST_FILL) && rd_data_en;
    assign ram_we     = strobe && (wcnt != WCNT_FULL) && wcnt[0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge sys_clk_shift or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = cache_hit ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_ISSUE, ST_WAIT_BUSY: begin
                if (rd_busy) begin
                    state_d = ST_FILL;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_FILL: begin
                if (busy_fall) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != ST_IDLE);
        rd_en = issuing;
        done  = (state_q == ST_FINISH) && fill_ok;
    end

    // Fill datapath: strobes past a full sector only raise overrun.
    always_ff @(posedge sys_clk_shift or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wcnt      <= '0;
            tcnt      <= '0;
            hi_half   <= '0;
            overrun   <= 1'b0;
            rd_busy_q <= 1'b0;
        end else begin
            rd_busy_q <= rd_busy;
            if (start_load) begin
                wcnt    <= '0;
                tcnt    <= '0;
                overrun <= 1'b0;
            end else begin
                if (issuing) begin
                    tcnt <= tcnt + 1'b1;
                end
                if (strobe) begin
                    if (wcnt == WCNT_FULL) begin
                        overrun <= 1'b1;
                    end else begin
                        if (!wcnt[0]) begin
                            hi_half <= rd_data;
                        end
                        wcnt <= wcnt + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge sys_clk_shift or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_addr    <= '0;
            cur_sector <= '0;
            buf_valid  <= 1'b0;
            err        <= 1'b0;
        end else if (accept) begin
            rd_addr    <= req_sector;
            cur_sector <= req_sector;
            err        <= 1'b0;
            if (!cache_hit) begin
                buf_valid <= 1'b0;
            end
        end else if (issuing && timeout) begin
            err <= 1'b1;
        end else if (state_q == ST_FINISH) begin
            buf_valid <= fill_ok;
            if (!fill_ok) begin
                err <= 1'b1;
            end
        end
    end

    // The first word of each pair lands in bits 31:16.
    sd_buf_ram #(
        .AW (AW),
        .DW (32)
    ) u_ram (
        .sys_clk_shift (sys_clk_shift),
        .sys_rst_n     (sys_rst_n),
        .we            (ram_we),
        .waddr         (wcnt[AW:1]),
        .wdata         ({hi_half, rd_data}),
        .raddr         (buf_raddr),
        .rdata         (buf_rdata)
    );

endmodule
